load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits between the CPU execute stage and the data memory. It accepts one load or store request at a time over a valid/ready handshake.
- It translates each request into the memory's write-port or read-port strobes and absorbs the memory's one-cycle registered read latency.
- It returns load data over a valid/ready response channel.
- It range-checks the CPU's 16-bit address against the memory address width and reports faults.

Parameters:
- DATA_WIDTH, 16, data word width; taken from CPU_package.
- ADDRESS_WIDTH, 8, memory address width; taken from CPU_package.
- CPU_ADDR_WIDTH, 16, width of the address supplied by the CPU.

Ports:
- clock  input  1  single clock; also drives the memory's Write_clock and Read_clock.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  request accepted this cycle when high together with req_valid.
- req_op  input  1  lsu_op_t: LSU_LOAD=0, LSU_STORE=1.
- req_address  input  CPU_ADDR_WIDTH  CPU byte-free word address.
- req_wdata  input  DATA_WIDTH  store data.
- resp_valid  output  1  load response present.
- resp_ready  input  1  consumer takes the response.
- resp_data  output  DATA_WIDTH  load data.
- resp_fault  output  1  the response belongs to an out-of-range load.
- fault_sticky  output  1  set by any out-of-range request; cleared only by reset.
- mem_write_address  output  ADDRESS_WIDTH  to memory write_address.
- mem_write_enable  output  1  to memory Write_Enable.
- mem_write_data  output  DATA_WIDTH  to memory DATA_WRITE.
- mem_read_address  output  ADDRESS_WIDTH  to memory read_address.
- mem_read_enable  output  1  to memory Read_Enable.
- mem_read_data  input  DATA_WIDTH  from memory DATA_READ; valid in the cycle after mem_read_enable.

Behaviour:
- Reset (asynchronous, active-high) values:
  - state=IDLE.
  - resp_valid=0, resp_data=0, resp_fault=0, fault_sticky=0.
  - All mem_* outputs = 0.
- Memory strobes are combinational from the state and the accepted request, so they are sampled by the memory at the same edge as the handshake.
- In-range rule: req_address[CPU_ADDR_WIDTH-1:ADDRESS_WIDTH] must be all zero. The memory address is req_address[ADDRESS_WIDTH-1:0].
- FSM states (lsu_state_t): IDLE, LOAD_WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid with an in-range STORE: mem_write_enable=1 with the address and data. The write completes at this edge. Stay in IDLE; there is no response.
  - On req_valid with an in-range LOAD: mem_read_enable=1 with the address. Go to LOAD_WAIT.
  - On req_valid with an out-of-range STORE: no memory strobe; the store is dropped and fault_sticky sets. Stay in IDLE.
  - On req_valid with an out-of-range LOAD: no memory strobe; fault_sticky sets. Go to RESP with resp_data=0 and resp_fault=1.
- LOAD_WAIT:
  - req_ready=0.
  - Capture mem_read_data into resp_data and set resp_fault=0 and resp_valid=1. Go to RESP.
- RESP:
  - req_ready=0.
  - resp_valid, resp_data and resp_fault are held stable until resp_ready=1.
  - On the handshake edge: resp_valid=0. Return to IDLE; the next request is accepted one cycle later.
- Latency:
  - Store: accepted and written in 1 cycle; back-to-back stores run every cycle.
  - Load: resp_valid asserts 2 cycles after acceptance. Best-case load throughput is 1 per 3 cycles.
- Ordering:
  - Requests are strictly serialized.
  - A store followed by a load to the same address returns the new data, because the write edge precedes the read edge.
  - No forwarding logic is required.
- Reset mid-load (in LOAD_WAIT or RESP) aborts the load and no response is produced. Memory contents are untouched; the memory has no reset.
- req_op, req_address and req_wdata are ignored when req_valid=0 or req_ready=0.
- mem_write_enable and mem_read_enable are never high in the same cycle.

Decomposition:
- Shared package CPU_package holds:
  - DATA_WIDTH, ADDRESS_WIDTH, ADDRESS_MAX_WIDTH and CPU_ADDR_WIDTH.
  - typedef enum logic lsu_op_t {LSU_LOAD, LSU_STORE}.
  - typedef enum logic [1:0] lsu_state_t {IDLE, LOAD_WAIT, RESP}.
- No sub-module. The address range check is a local function. The unit is instantiated beside the data memory in the CPU top.

Test Plan:
- STORE 0x00A5←0x1234 then LOAD 0x00A5 with resp_ready=1 -> mem_write_enable is high for 1 cycle; resp_valid asserts 2 cycles after the load is accepted with resp_data=0x1234 and resp_fault=0.
- Back-to-back stores to 0x0001..0x0004 with data 0x0011..0x0044 -> req_ready stays 1 and 4 write strobes occur in 4 consecutive cycles; a subsequent load of 0x0003 returns 0x0033.
- LOAD 0x0010 with resp_ready=0 for 5 cycles -> resp_valid and resp_data are held stable and req_ready=0 throughout; the handshake returns the unit to IDLE and the next request is accepted the cycle after.
- STORE to 0x0100 and LOAD from 0xFF00 -> no mem strobes; the load returns resp_data=0 with resp_fault=1; fault_sticky=1; a later in-range load returns resp_fault=0.
- Assert reset while in LOAD_WAIT -> resp_valid never asserts and all outputs immediately hold their reset values; after release, a LOAD of the previously stored address returns the stored data.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// CPU_package: shared widths and types for the CPU data path.
// Holds the memory/CPU address widths, the data word width and the
// load/store unit operation and state encodings.
package CPU_package;

  localparam int DATA_WIDTH        = 16;
  localparam int ADDRESS_WIDTH     = 8;
  // Number of words addressable in the data memory.
  localparam int ADDRESS_MAX_WIDTH = 1 << ADDRESS_WIDTH;
  localparam int CPU_ADDR_WIDTH    = 16;

  typedef enum logic {
    LSU_LOAD  = 1'b0,
    LSU_STORE = 1'b1
  } lsu_op_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    RESP      = 2'd2
  } lsu_state_t;

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake between the CPU execute stage and the
// load/store unit.
//   req_valid/req_ready   : request handshake (CPU -> LSU)
//   req_op/address/wdata  : request payload
//   resp_valid/resp_ready : load response handshake (LSU -> CPU)
//   resp_data/resp_fault  : response payload
// Modports: master = CPU side, slave = load/store unit side.
interface load_store_unit_if;
  import CPU_package::*;

  logic                      req_valid;
  logic                      req_ready;
  lsu_op_t                   req_op;
  logic [CPU_ADDR_WIDTH-1:0] req_address;
  logic [DATA_WIDTH-1:0]     req_wdata;
  logic                      resp_valid;
  logic                      resp_ready;
  logic [DATA_WIDTH-1:0]     resp_data;
  logic                      resp_fault;

  modport master (
    output req_valid, req_op, req_address, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_fault
  );

  modport slave (
    input  req_valid, req_op, req_address, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_data, resp_fault
  );

endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: serializes CPU load/store requests onto the data
// memory's write and read ports, absorbs the one-cycle registered read
// latency and returns load data over a valid/ready response channel.
// Out-of-range addresses never reach the memory; they set fault_sticky,
// and loads return a faulted zero response.
// Ports:
//   clock, reset        : clock and asynchronous active-high reset
//   bus (slave)         : request/response handshake with the CPU
//   fault_sticky        : any out-of-range request seen since reset
//   mem_write_*         : memory write port strobes
//   mem_read_*          : memory read port strobes and returned data
module load_store_unit
  import CPU_package::*;
(
  input  logic                     clock,
  input  logic                     reset,
  load_store_unit_if.slave         bus,
  output logic                     fault_sticky,
  output logic [ADDRESS_WIDTH-1:0] mem_write_address,
  output logic                     mem_write_enable,
  output logic [DATA_WIDTH-1:0]    mem_write_data,
  output logic [ADDRESS_WIDTH-1:0] mem_read_address,
  output logic                     mem_read_enable,
  input  logic [DATA_WIDTH-1:0]    mem_read_data
);

  // An address is legal when every bit above the memory width is zero.
  function automatic logic in_range(input logic [CPU_ADDR_WIDTH-1:0] address);
    return address[CPU_ADDR_WIDTH-1:ADDRESS_WIDTH] == '0;
  endfunction

  lsu_state_t state, next_state;
  logic       accept;
  logic       address_ok;
  logic       is_store;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of its inputs.
      state <= next_state;
    end
  end

  // Next-state and memory strobes. Strobes are combinational so the
  // memory samples them at the same edge that completes the handshake.
  // Reset forces them low so nothing reaches memory while held in reset.
  always_comb begin
    // NOTE: every output gets a default first; otherwise paths that skip
    // an assignment would infer latches.
    next_state        = state;
    bus.req_ready     = 1'b0;
    accept            = 1'b0;
    address_ok        = in_range(bus.req_address);
    is_store          = (bus.req_op == LSU_STORE);
    mem_write_enable  = 1'b0;
    mem_write_address = '0;
    mem_write_data    = '0;
    mem_read_enable   = 1'b0;
    mem_read_address  = '0;

    if (!reset) begin
      unique case (state)
        IDLE: begin
          bus.req_ready = 1'b1;
          if (bus.req_valid) begin
            accept = 1'b1;
            if (address_ok) begin
              if (is_store) begin
                mem_write_enable  = 1'b1;
                mem_write_address = bus.req_address[ADDRESS_WIDTH-1:0];
                mem_write_data    = bus.req_wdata;
              end else begin
                mem_read_enable  = 1'b1;
                mem_read_address = bus.req_address[ADDRESS_WIDTH-1:0];
                next_state       = LOAD_WAIT;
              end
            end else if (!is_store) begin
              // Faulted load skips memory and answers directly.
              next_state = RESP;
            end
          end
        end
        LOAD_WAIT: next_state = RESP;
        RESP:      if (bus.resp_ready) next_state = IDLE;
        default:   next_state = IDLE;
      endcase
    end
  end

  // Response registers and the sticky fault flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.resp_valid <= 1'b0;
      bus.resp_data  <= '0;
      bus.resp_fault <= 1'b0;
      fault_sticky   <= 1'b0;
    end else begin
      if (accept && !address_ok) begin
        fault_sticky <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (accept && !address_ok && !is_store) begin
            bus.resp_valid <= 1'b1;
            bus.resp_data  <= '0;
            bus.resp_fault <= 1'b1;
          end
        end
        LOAD_WAIT: begin
          // Read data is valid the cycle after mem_read_enable.
          bus.resp_valid <= 1'b1;
          bus.resp_data  <= mem_read_data;
          bus.resp_fault <= 1'b0;
        end
        RESP: begin
          if (bus.resp_ready) bus.resp_valid <= 1'b0;
        end
        default: bus.resp_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a directed vector table, a
// reset-during-load sequence, then randomized traffic compared against a
// word-addressed reference memory.
module tb_load_store_unit;
  import CPU_package::*;

  logic                     clock;
  logic                     reset;
  logic                     fault_sticky;
  logic [ADDRESS_WIDTH-1:0] mem_write_address;
  logic                     mem_write_enable;
  logic [DATA_WIDTH-1:0]    mem_write_data;
  logic [ADDRESS_WIDTH-1:0] mem_read_address;
  logic                     mem_read_enable;
  logic [DATA_WIDTH-1:0]    mem_read_data;

  load_store_unit_if bus ();

  load_store_unit dut (
    .clock             (clock),
    .reset             (reset),
    .bus               (bus),
    .fault_sticky      (fault_sticky),
    .mem_write_address (mem_write_address),
    .mem_write_enable  (mem_write_enable),
    .mem_write_data    (mem_write_data),
    .mem_read_address  (mem_read_address),
    .mem_read_enable   (mem_read_enable),
    .mem_read_data     (mem_read_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Data memory: synchronous write, one-cycle registered read, no reset.
  logic [DATA_WIDTH-1:0] memory [ADDRESS_MAX_WIDTH];
  always @(posedge clock) begin
    if (mem_write_enable) memory[mem_write_address] <= mem_write_data;
    if (mem_read_enable)  mem_read_data <= memory[mem_read_address];
  end

  // Reference model state.
  logic [DATA_WIDTH-1:0] ref_mem [int];
  int                    written [$];
  logic                  ref_sticky;

  int checks;
  int errors;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, actual, required, $time);
    end
  endtask

  function automatic logic addr_ok(input logic [15:0] a);
    return a < 16'(ADDRESS_MAX_WIDTH);
  endfunction

  // One store request; leaves req_valid high so stores can run back to back.
  task automatic do_store(input logic [15:0] addr, input logic [15:0] data, input logic exp_strobe);
    @(negedge clock);
    check("sticky_before_store", 32'(fault_sticky), 32'(ref_sticky));
    bus.req_valid   = 1'b1;
    bus.req_op      = LSU_STORE;
    bus.req_address = addr;
    bus.req_wdata   = data;
    #1;
    check("store_req_ready", 32'(bus.req_ready), 32'd1);
    check("store_we", 32'(mem_write_enable), 32'(exp_strobe));
    check("store_re", 32'(mem_read_enable), 32'd0);
    if (exp_strobe) begin
      check("store_waddr", 32'(mem_write_address), 32'(addr[7:0]));
      check("store_wdata", 32'(mem_write_data), 32'(data));
    end
    @(posedge clock);
    if (exp_strobe) ref_mem[int'(addr[7:0])] = data;
    else ref_sticky = 1'b1;
  endtask

  // One load request through to the response handshake.
  task automatic do_load(input logic [15:0] addr, input logic exp_strobe, input int hold,
                         input logic [15:0] exp_data, input logic exp_fault);
    @(negedge clock);
    check("sticky_before_load", 32'(fault_sticky), 32'(ref_sticky));
    bus.req_valid   = 1'b1;
    bus.req_op      = LSU_LOAD;
    bus.req_address = addr;
    bus.req_wdata   = 16'($urandom);
    bus.resp_ready  = 1'b0;
    #1;
    check("load_req_ready", 32'(bus.req_ready), 32'd1);
    check("load_re", 32'(mem_read_enable), 32'(exp_strobe));
    check("load_we", 32'(mem_write_enable), 32'd0);
    if (exp_strobe) check("load_raddr", 32'(mem_read_address), 32'(addr[7:0]));
    @(posedge clock);
    if (!exp_strobe) ref_sticky = 1'b1;
    @(negedge clock);
    bus.req_valid = 1'b0;
    if (exp_strobe) begin
      #1;
      check("wait_resp_valid", 32'(bus.resp_valid), 32'd0);
      check("wait_req_ready", 32'(bus.req_ready), 32'd0);
      check("wait_re", 32'(mem_read_enable), 32'd0);
      @(negedge clock);
    end
    #1;
    check("resp_valid", 32'(bus.resp_valid), 32'd1);
    check("resp_data", 32'(bus.resp_data), 32'(exp_data));
    check("resp_fault", 32'(bus.resp_fault), 32'(exp_fault));
    check("resp_req_ready", 32'(bus.req_ready), 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      #1;
      check("hold_valid", 32'(bus.resp_valid), 32'd1);
      check("hold_data", 32'(bus.resp_data), 32'(exp_data));
      check("hold_fault", 32'(bus.resp_fault), 32'(exp_fault));
      check("hold_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.resp_ready = 1'b1;
    @(negedge clock);
    bus.resp_ready = 1'b0;
    #1;
    check("after_hs_valid", 32'(bus.resp_valid), 32'd0);
    check("after_hs_req_ready", 32'(bus.req_ready), 32'd1);
  endtask

  typedef struct {
    lsu_op_t     op;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          hold;
    logic        exp_strobe;
    logic [15:0] exp_data;
    logic        exp_fault;
  } vec_t;

  vec_t vecs [12];

  initial begin
    checks          = 0;
    errors          = 0;
    ref_sticky      = 1'b0;
    reset           = 1'b1;
    bus.req_valid   = 1'b0;
    bus.req_op      = LSU_LOAD;
    bus.req_address = '0;
    bus.req_wdata   = '0;
    bus.resp_ready  = 1'b0;

    vecs[0]  = '{LSU_STORE, 16'h00A5, 16'h1234, 0, 1'b1, 16'h0000, 1'b0};
    vecs[1]  = '{LSU_LOAD,  16'h00A5, 16'h0000, 0, 1'b1, 16'h1234, 1'b0};
    vecs[2]  = '{LSU_STORE, 16'h0001, 16'h0011, 0, 1'b1, 16'h0000, 1'b0};
    vecs[3]  = '{LSU_STORE, 16'h0002, 16'h0022, 0, 1'b1, 16'h0000, 1'b0};
    vecs[4]  = '{LSU_STORE, 16'h0003, 16'h0033, 0, 1'b1, 16'h0000, 1'b0};
    vecs[5]  = '{LSU_STORE, 16'h0004, 16'h0044, 0, 1'b1, 16'h0000, 1'b0};
    vecs[6]  = '{LSU_LOAD,  16'h0003, 16'h0000, 0, 1'b1, 16'h0033, 1'b0};
    vecs[7]  = '{LSU_STORE, 16'h0010, 16'hBEEF, 0, 1'b1, 16'h0000, 1'b0};
    vecs[8]  = '{LSU_LOAD,  16'h0010, 16'h0000, 5, 1'b1, 16'hBEEF, 1'b0};
    vecs[9]  = '{LSU_STORE, 16'h0100, 16'hDEAD, 0, 1'b0, 16'h0000, 1'b0};
    vecs[10] = '{LSU_LOAD,  16'hFF00, 16'h0000, 1, 1'b0, 16'h0000, 1'b1};
    vecs[11] = '{LSU_LOAD,  16'h0001, 16'h0000, 0, 1'b1, 16'h0011, 1'b0};

    // Reset state, including strobes held low despite a pending request.
    #2;
    bus.req_valid   = 1'b1;
    bus.req_op      = LSU_STORE;
    bus.req_address = 16'h0007;
    #1;
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_data", 32'(bus.resp_data), 32'd0);
    check("rst_resp_fault", 32'(bus.resp_fault), 32'd0);
    check("rst_sticky", 32'(fault_sticky), 32'd0);
    check("rst_we", 32'(mem_write_enable), 32'd0);
    check("rst_re", 32'(mem_read_enable), 32'd0);
    check("rst_waddr", 32'(mem_write_address), 32'd0);
    bus.req_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Directed table.
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].op == LSU_STORE) begin
        do_store(vecs[i].addr, vecs[i].wdata, vecs[i].exp_strobe);
        if (vecs[i].exp_strobe) written.push_back(int'(vecs[i].addr[7:0]));
      end else begin
        do_load(vecs[i].addr, vecs[i].exp_strobe, vecs[i].hold, vecs[i].exp_data, vecs[i].exp_fault);
      end
    end
    @(negedge clock);
    bus.req_valid = 1'b0;
    #1;
    check("idle_we", 32'(mem_write_enable), 32'd0);
    check("sticky_after_table", 32'(fault_sticky), 32'd1);

    // Reset while the load is in LOAD_WAIT: no response, memory kept.
    do_store(16'h0055, 16'hA5A5, 1'b1);
    written.push_back(32'h55);
    @(negedge clock);
    bus.req_op      = LSU_LOAD;
    bus.req_address = 16'h0055;
    @(posedge clock);
    @(negedge clock);
    bus.req_valid   = 1'b1;
    bus.req_op      = LSU_STORE;
    bus.req_address = 16'h0055;
    bus.req_wdata   = 16'h0BAD;
    reset           = 1'b1;
    #1;
    check("mid_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("mid_rst_resp_data", 32'(bus.resp_data), 32'd0);
    check("mid_rst_sticky", 32'(fault_sticky), 32'd0);
    check("mid_rst_we", 32'(mem_write_enable), 32'd0);
    check("mid_rst_re", 32'(mem_read_enable), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      #1;
      check("mid_rst_hold_valid", 32'(bus.resp_valid), 32'd0);
    end
    bus.req_valid = 1'b0;
    reset         = 1'b0;
    ref_sticky    = 1'b0;
    @(negedge clock);
    #1;
    check("post_rst_valid", 32'(bus.resp_valid), 32'd0);
    check("post_rst_req_ready", 32'(bus.req_ready), 32'd1);
    do_load(16'h0055, 1'b1, 0, 16'hA5A5, 1'b0);

    // Randomized traffic against the reference memory.
    for (int n = 0; n < 60; n++) begin
      logic        in;
      logic [15:0] a;
      in = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) begin
        a = in ? {8'h00, 8'($urandom)} : 16'($urandom_range(256, 65535));
        do_store(a, 16'($urandom), in);
        if (in) written.push_back(int'(a[7:0]));
      end else if (in) begin
        a = 16'(written[$urandom_range(0, written.size() - 1)]);
        do_load(a, 1'b1, $urandom_range(0, 2), ref_mem[int'(a[7:0])], 1'b0);
      end else begin
        a = 16'($urandom_range(256, 65535));
        do_load(a, 1'b0, $urandom_range(0, 2), 16'h0000, 1'b1);
      end
    end
    @(negedge clock);
    bus.req_valid = 1'b0;
    check("final_sticky", 32'(fault_sticky), 32'(ref_sticky));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
